// File: rtl/ro_puf_vote.sv
// Ring-oscillator PUF: counts edges per ring over a window, compares ring pairs, majority-votes VOTES runs.
// Ready rises VOTES*(1+WINDOW+RESP_W)+1 cycles after an accepted start; start is ignored while busy or en low.
module ro_puf_vote #(
  parameter int NUM_RO  = 16,
  parameter int CHALL_W = 8,
  parameter int RESP_W  = 8,
  parameter int CNT_W   = 16,
  parameter int WINDOW  = 1024,
  parameter int VOTES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [CHALL_W-1:0] chall_in,
  input  logic [NUM_RO-1:0]  ro_in,
  output logic [RESP_W-1:0]  response,
  output logic               ready,
  output logic               busy,
  output logic               unstable
);

  localparam int IDX_W  = $clog2(NUM_RO);
  localparam int HALF   = CHALL_W / 2;
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int BIT_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int VOTE_W = $clog2(VOTES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, COMPARE, DONE} state_t;

  state_t              r_state;
  state_t              w_next;

  logic [NUM_RO-1:0]   r_sync1;
  logic [NUM_RO-1:0]   r_sync2;
  logic [NUM_RO-1:0]   r_prev;
  logic [CNT_W-1:0]    r_cnt [NUM_RO];
  logic [WIN_W-1:0]    r_win;
  logic [BIT_W-1:0]    r_bit;
  logic [VOTE_W-1:0]   r_votes;
  logic [VOTE_W-1:0]   r_ones [RESP_W];
  logic [CHALL_W-1:0]  r_chall;
  logic [RESP_W-1:0]   r_resp;
  logic                r_ready;
  logic                r_busy;
  logic                r_unst;

  logic [NUM_RO-1:0]   w_edge;
  logic [IDX_W-1:0]    w_a;
  logic [IDX_W-1:0]    w_b;
  logic                w_vote;
  logic                w_accept;
  logic                w_last_bit;
  logic                w_more_votes;
  logic                w_finalize;
  logic [RESP_W-1:0]   w_resp_fin;
  logic                w_unst_fin;

  assign w_edge       = r_sync2 & ~r_prev;
  assign w_accept     = en && start && !r_busy && (r_state == IDLE || r_state == DONE);
  assign w_last_bit   = (32'(r_bit) == 32'(RESP_W - 1));
  assign w_more_votes = (32'(r_votes) + 32'd1) < 32'(VOTES);
  // Response is published one cycle after DONE is entered, once the last vote has landed.
  assign w_finalize   = (r_state == DONE) && r_busy;

  // Offset of B from A is 1..NUM_RO-1, so the pair never collapses onto one ring.
  assign w_a = IDX_W'((32'(r_chall[HALF-1:0]) + 32'(r_bit) * 32'd2) % 32'(NUM_RO));
  assign w_b = IDX_W'((32'(w_a) + 32'd1 + 32'(r_chall[CHALL_W-1:HALF]) % 32'(NUM_RO - 1))
                      % 32'(NUM_RO));
  assign w_vote = r_cnt[w_a] > r_cnt[w_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CLEAR;
      CLEAR:   if (en) w_next = COUNT;
      COUNT:   if (en && r_win == WIN_W'(WINDOW - 1)) w_next = COMPARE;
      COMPARE: if (en && w_last_bit) w_next = w_more_votes ? CLEAR : DONE;
      DONE:    if (w_accept) w_next = CLEAR;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_resp_fin = '0;
    w_unst_fin = 1'b0;
    for (int k = 0; k < RESP_W; k++) begin
      w_resp_fin[k] = 32'(r_ones[k]) > 32'(VOTES / 2);
      if (r_ones[k] != '0 && 32'(r_ones[k]) != 32'(VOTES)) w_unst_fin = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_win   <= '0;
      r_bit   <= '0;
      r_votes <= '0;
      r_chall <= '0;
      r_resp  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_unst  <= 1'b0;
      for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
      for (int k = 0; k < RESP_W; k++) r_ones[k] <= '0;
    end else begin
      r_sync1 <= ro_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (w_accept) begin
        r_chall <= chall_in;
        r_votes <= '0;
        r_resp  <= '0;
        r_unst  <= 1'b0;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
        for (int k = 0; k < RESP_W; k++) r_ones[k] <= '0;
      end

      // en low freezes the whole evaluation, not just the ring counters.
      if (en) begin
        case (r_state)
          CLEAR: begin
            for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
            r_win <= '0;
            r_bit <= '0;
          end
          COUNT: begin
            for (int i = 0; i < NUM_RO; i++) begin
              if (w_edge[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            r_win <= r_win + 1'b1;
          end
          COMPARE: begin
            r_ones[r_bit] <= r_ones[r_bit] + VOTE_W'(w_vote);
            if (w_last_bit) begin
              r_bit   <= '0;
              r_votes <= r_votes + 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (w_finalize) begin
        r_resp  <= w_resp_fin;
        r_unst  <= w_unst_fin;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign response = r_resp;
  assign ready    = r_ready;
  assign busy     = r_busy;
  assign unstable = r_unst;

endmodule

// File: tb/tb_ro_puf_vote.sv
// Bench for ro_puf_vote: table of directed vectors, reset/enable corner sequences, and random rings vs. a count model.
module tb_ro_puf_vote;
  localparam int NR  = 4;
  localparam int CW  = 4;
  localparam int RW  = 2;
  localparam int CNW = 16;
  localparam int WIN = 16;
  localparam int VT  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [CW-1:0] chall_in;
  logic [NR-1:0] ro_in;
  logic [RW-1:0] response;
  logic          ready;
  logic          busy;
  logic          unstable;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int per [NR];
  int ph  [NR];
  int plist [5] = '{0, 2, 4, 8, 16};

  ro_puf_vote #(
    .NUM_RO(NR), .CHALL_W(CW), .RESP_W(RW), .CNT_W(CNW), .WINDOW(WIN), .VOTES(VT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .chall_in(chall_in), .ro_in(ro_in),
    .response(response), .ready(ready), .busy(busy), .unstable(unstable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] p;
    logic [3:0]      ch;
    int              pause_at;
    bit              poke;
    bit              swap;
    logic [1:0]      resp;
    logic            unst;
    int              lat;
  } vec_t;

  function automatic vec_t mk(logic [3:0][7:0] p, logic [3:0] ch, int pa, bit pk, bit sw,
                              logic [1:0] r, logic u, int l);
    vec_t v;
    v.p = p; v.ch = ch; v.pause_at = pa; v.poke = pk; v.swap = sw;
    v.resp = r; v.unst = u; v.lat = l;
    return v;
  endfunction

  task automatic drive_rings();
    for (int i = 0; i < NR; i++)
      ro_in[i] = (per[i] == 0) ? 1'b0 : (((cyc + ph[i]) % per[i]) < per[i] / 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_rings();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Periodic ring with period p shows exactly WIN/p rising edges in any WIN consecutive cycles.
  function automatic logic [1:0] model(logic [3:0] ch);
    logic [1:0] r;
    int a, b, ca, cb;
    r = '0;
    for (int k = 0; k < RW; k++) begin
      a  = (int'(ch[1:0]) + 2 * k) % NR;
      b  = (a + 1 + (int'(ch[3:2]) % (NR - 1))) % NR;
      ca = (per[a] == 0) ? 0 : WIN / per[a];
      cb = (per[b] == 0) ? 0 : WIN / per[b];
      r[k] = ca > cb;
    end
    return r;
  endfunction

  task automatic run_eval(input logic [3:0] ch, input int pause_at, input bit poke,
                          input bit swap, output int lat);
    chall_in = ch;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready", ready, 0);
    lat = 0;
    while (ready !== 1'b1 && lat < 400) begin
      if (pause_at >= 0 && lat == pause_at) en = 1'b0;
      if (pause_at >= 0 && lat == pause_at + 10) en = 1'b1;
      if (poke && lat == 30) begin start = 1'b1; chall_in = ~ch; end
      if (poke && lat == 31) start = 1'b0;
      if (swap && (lat == 18 || lat == 37)) begin
        int t;
        t = per[0]; per[0] = per[1]; per[1] = t;
      end
      tick();
      lat++;
    end
    if (lat >= 400) $display("FAIL ready_timeout: got no ready, expected ready within 400 cycles");
  endtask

  vec_t tbl [5];
  int   lat;
  logic [1:0] exp_r;

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; chall_in = '0; ro_in = '0;
    for (int i = 0; i < NR; i++) begin per[i] = 0; ph[i] = 0; end

    tbl[0] = mk({8'd4, 8'd0, 8'd8, 8'd4}, 4'b0000, -1, 0, 0, 2'b01, 1'b0, 58);
    tbl[1] = mk({8'd4, 8'd0, 8'd8, 8'd4}, 4'b0100, -1, 0, 0, 2'b01, 1'b0, 58);
    tbl[2] = mk({8'd4, 8'd4, 8'd4, 8'd4}, 4'b1011, -1, 0, 0, 2'b00, 1'b0, 58);
    tbl[3] = mk({8'd4, 8'd0, 8'd8, 8'd4}, 4'b0000,  8, 0, 0, 2'b01, 1'b0, 68);
    tbl[4] = mk({8'd0, 8'd0, 8'd0, 8'd4}, 4'b0000, -1, 0, 1, 2'b01, 1'b1, 58);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_resp", response, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_unst", unstable, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_en0_busy", busy, 0);
    en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NR; i++) begin per[i] = int'(tbl[v].p[i]); ph[i] = 0; end
      repeat (4) tick();
      run_eval(tbl[v].ch, tbl[v].pause_at, 1'b0, tbl[v].swap, lat);
      check($sformatf("v%0d_lat", v), lat, tbl[v].lat);
      check($sformatf("v%0d_resp", v), response, tbl[v].resp);
      check($sformatf("v%0d_unst", v), unstable, tbl[v].unst);
      check($sformatf("v%0d_busy_done", v), busy, 0);
      repeat (3) tick();
      check($sformatf("v%0d_hold_ready", v), ready, 1);
      check($sformatf("v%0d_hold_resp", v), response, tbl[v].resp);
    end

    // start and challenge change while busy must leave the run untouched
    for (int i = 0; i < NR; i++) per[i] = int'(tbl[0].p[i]);
    repeat (4) tick();
    run_eval(4'b0000, -1, 1'b1, 1'b0, lat);
    check("poke_lat", lat, 58);
    check("poke_resp", response, 2'b01);

    // reset during the first COMPARE, then a clean rerun
    repeat (2) tick();
    chall_in = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    check("midrst_resp", response, 0);
    check("midrst_unst", unstable, 0);
    rst = 1'b0;
    repeat (4) tick();
    run_eval(4'b0000, -1, 1'b0, 1'b0, lat);
    check("postrst_lat", lat, 58);
    check("postrst_resp", response, 2'b01);
    check("postrst_unst", unstable, 0);

    for (int r = 0; r < 20; r++) begin
      logic [3:0] ch;
      for (int i = 0; i < NR; i++) begin
        per[i] = plist[$urandom_range(0, 4)];
        ph[i]  = int'($urandom_range(0, 15));
      end
      ch = 4'($urandom_range(0, 15));
      exp_r = model(ch);
      repeat (4) tick();
      run_eval(ch, -1, 1'b0, 1'b0, lat);
      check($sformatf("rnd%0d_lat", r), lat, 58);
      check($sformatf("rnd%0d_resp", r), response, exp_r);
      check($sformatf("rnd%0d_unst", r), unstable, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
